// File: rtl/seq_game_pkg.sv
// Shared types and helpers for the sequence-memory game engine.
package seq_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_GAP_PRE,
        ST_INPUT,
        ST_WIN,
        ST_LOSE
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          LEVEL_W   = 5;

    function automatic logic [15:0] onehot(input logic [3:0] sym);
        onehot = 16'd1 << sym;
    endfunction

endpackage

// File: rtl/seq_lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR; exposes only the low symbol bits.
module seq_lfsr16
    import seq_game_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] sym_o
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [15:0] SEED_FIX = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED_FIX;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign sym_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/seq_game_core.sv
// Sequence-memory game: loads a random sequence, replays a growing prefix on
// the LEDs and scores the player's presses against it.
module seq_game_core
    import seq_game_pkg::*;
#(
    parameter int          KEY_W         = 2,
    parameter int          MAX_LEVEL     = 8,
    parameter int          SHOW_TICKS    = 2,
    parameter int          GAP_TICKS     = 1,
    parameter int          TIMEOUT_TICKS = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         NUM_KEYS      = 2**KEY_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic [NUM_KEYS-1:0] b,
    output logic [NUM_KEYS-1:0] l,
    output logic [4:0]          level,
    output logic                busy,
    output logic                win,
    output logic                lose
);

    localparam int IDX_W  = $clog2(MAX_LEVEL);
    localparam int TMAX   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TCNT_W = $clog2(TMAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [TCNT_W-1:0]  SHOW_LAST = TCNT_W'(SHOW_TICKS - 1);
    localparam logic [TCNT_W-1:0]  GAP_LAST  = TCNT_W'(GAP_TICKS - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(MAX_LEVEL - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(MAX_LEVEL);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [TO_W-1:0]      tocnt_q, tocnt_d;
    logic                 any_prev_q;
    logic [KEY_W-1:0]     seq_q [MAX_LEVEL];

    logic [KEY_W-1:0]     sym;
    logic                 any_key;
    logic                 press;
    logic [NUM_KEYS-1:0]  cur_oh;
    logic                 more_in_level;

    seq_lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (KEY_W)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .sym_o (sym)
    );

    // any_prev_q tracks b in every state, so a key held into INPUT is not an edge.
    assign any_key       = |b;
    assign press         = any_key & ~any_prev_q;
    assign cur_oh        = NUM_KEYS'(onehot(4'(seq_q[idx_q])));
    assign more_in_level = (LEVEL_W'(idx_q) + LEVEL_W'(1)) < level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            level_q    <= LEVEL_W'(1);
            tcnt_q     <= '0;
            tocnt_q    <= '0;
            any_prev_q <= 1'b0;
            for (int i = 0; i < MAX_LEVEL; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            level_q    <= level_d;
            tcnt_q     <= tcnt_d;
            tocnt_q    <= tocnt_d;
            any_prev_q <= any_key;
            if (state_q == ST_LOAD) begin
                seq_q[idx_q] <= sym;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        level_d = level_q;
        tcnt_d  = tcnt_q;
        tocnt_d = tocnt_q;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    level_d = LEVEL_W'(1);
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_SHOW_ON;
                    idx_d   = '0;
                    tcnt_d  = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_SHOW_ON: begin
                if (tick) begin
                    if (tcnt_q >= SHOW_LAST) begin
                        state_d = ST_SHOW_OFF;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            ST_SHOW_OFF: begin
                if (tick) begin
                    if (tcnt_q >= GAP_LAST) begin
                        tcnt_d = '0;
                        if (more_in_level) begin
                            state_d = ST_SHOW_ON;
                            idx_d   = idx_q + IDX_W'(1);
                        end else begin
                            state_d = ST_INPUT;
                            idx_d   = '0;
                            tocnt_d = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            ST_GAP_PRE: begin
                if (tick) begin
                    if (tcnt_q >= GAP_LAST) begin
                        state_d = ST_SHOW_ON;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            ST_INPUT: begin
                // A press takes priority over a timeout landing in the same cycle.
                if (press) begin
                    tocnt_d = '0;
                    if (b != cur_oh) begin
                        state_d = ST_LOSE;
                    end else if (more_in_level) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (level_q >= LVL_MAX) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_GAP_PRE;
                        level_d = level_q + LEVEL_W'(1);
                        idx_d   = '0;
                        tcnt_d  = '0;
                    end
                end else if (tick) begin
                    if (tocnt_q >= TO_LAST) begin
                        state_d = ST_LOSE;
                    end else begin
                        tocnt_d = tocnt_q + TO_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        l    = '0;
        busy = 1'b0;
        win  = 1'b0;
        lose = 1'b0;
        case (state_q)
            ST_LOAD, ST_SHOW_OFF, ST_GAP_PRE: busy = 1'b1;
            ST_SHOW_ON: begin
                busy = 1'b1;
                l    = cur_oh;
            end
            ST_INPUT: l = b;
            ST_WIN: begin
                win = 1'b1;
                l   = '1;
            end
            ST_LOSE: lose = 1'b1;
            default: ;
        endcase
    end

    assign level = level_q;

endmodule
